// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Holds the phase enum, the index-width helper and the default lamp durations.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_ALLRED_T = 2;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Free-running prescaler: tick is a one-cycle pulse when the count reaches TICK_DIV-1.
// tick is combinational from the count register; the count wraps to 0 on the following edge.
module traffic_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach signal controller: demand-driven round robin, all-red clearance, night flashing.
// Every state change lands one cycle after the Tick that caused it; lamps are registered.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 4,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  localparam int IDX_W   = idx_w(NUM_DIR)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [CNT_W-1:0]   Green_time,
  input  logic [NUM_DIR-1:0] Demand,
  input  logic               Night_mode,
  output logic [NUM_DIR-1:0] Red,
  output logic [NUM_DIR-1:0] Yellow,
  output logic [NUM_DIR-1:0] Green,
  output logic [CNT_W-1:0]   Remain,
  output logic [IDX_W-1:0]   Active,
  output logic               Tick
);

  localparam logic [CNT_W-1:0] ALLRED_LD = (ALLRED_T == 0) ? CNT_W'(1) : CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] YELLOW_LD = (YELLOW_T == 0) ? CNT_W'(1) : CNT_W'(YELLOW_T);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic               flash_q, flash_d;
  logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic [CNT_W-1:0]   green_ld;
  logic [IDX_W-1:0]   next_idx;
  logic [NUM_DIR-1:0] sel_1h;
  logic               tick;

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (Clk),
    .reset (Reset),
    .tick  (tick)
  );

  assign green_ld = (Green_time == '0) ? CNT_W'(1) : Green_time;

  // Round robin from the slot after Active; Active itself is the last candidate.
  always_comb begin : rr_scan
    logic             found;
    logic [IDX_W-1:0] j;
    found    = 1'b0;
    j        = '0;
    next_idx = IDX_W'((int'(active_q) + 1) % NUM_DIR);
    for (int k = 1; k <= NUM_DIR; k++) begin
      j = IDX_W'((int'(active_q) + k) % NUM_DIR);
      if (!found && Demand[j]) begin
        next_idx = j;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    active_d = active_q;
    flash_d  = flash_q;
    if (tick) begin
      if (Night_mode) begin
        state_d  = ST_FLASH;
        remain_d = '0;
        flash_d  = (state_q == ST_FLASH) ? ~flash_q : 1'b1;
      end else if (state_q == ST_FLASH) begin
        state_d  = ST_ALLRED;
        remain_d = ALLRED_LD;
      end else if (remain_q > CNT_W'(1)) begin
        remain_d = remain_q - CNT_W'(1);
      end else begin
        case (state_q)
          ST_ALLRED: begin
            state_d  = ST_GREEN;
            remain_d = green_ld;
          end
          ST_GREEN: begin
            if (Demand == (NUM_DIR'(1) << active_q)) begin
              remain_d = green_ld;
            end else begin
              state_d  = ST_YELLOW;
              remain_d = YELLOW_LD;
            end
          end
          ST_YELLOW: begin
            state_d  = ST_ALLRED;
            remain_d = ALLRED_LD;
            active_d = next_idx;
          end
          default: ;
        endcase
      end
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    sel_1h   = NUM_DIR'(1) << active_d;
    red_d    = {NUM_DIR{1'b1}};
    yellow_d = '0;
    green_d  = '0;
    case (state_d)
      ST_GREEN: begin
        green_d = sel_1h;
        red_d   = ~sel_1h;
      end
      ST_YELLOW: begin
        yellow_d = sel_1h;
        red_d    = ~sel_1h;
      end
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIR{flash_d}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_ALLRED;
      remain_q <= ALLRED_LD;
      active_q <= '0;
      flash_q  <= 1'b0;
      red_q    <= {NUM_DIR{1'b1}};
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      active_q <= active_d;
      flash_q  <= flash_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign Red    = red_q;
  assign Yellow = yellow_q;
  assign Green  = green_q;
  assign Remain = remain_q;
  assign Active = active_q;
  assign Tick   = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised bench for traffic_phase_ctrl against a tick-level behavioural model of the phase rules.
module tb_traffic_phase_ctrl;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int TDIV = 4;
  localparam int YT   = 3;
  localparam int ART  = 2;

  localparam int P_AR = 0;
  localparam int P_GR = 1;
  localparam int P_YE = 2;
  localparam int P_FL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] green_time;
  logic [N-1:0]  demand;
  logic          night_mode;
  logic [N-1:0]  red, yellow, green;
  logic [CW-1:0] remain;
  logic [1:0]    active;
  logic          tick;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int m_pre, m_phase, m_left, m_active;
  bit m_flash;

  traffic_phase_ctrl #(
    .NUM_DIR(N), .CNT_W(CW), .TICK_DIV(TDIV), .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .Clk(clk), .Reset(reset), .Green_time(green_time), .Demand(demand),
    .Night_mode(night_mode), .Red(red), .Yellow(yellow), .Green(green),
    .Remain(remain), .Active(active), .Tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_served(input int a, input logic [N-1:0] d);
    if (d == '0) return (a + 1) % N;
    for (int k = 1; k <= N; k++)
      if (d[(a + k) % N]) return (a + k) % N;
    return a;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit t;
    int gdur;
    if (reset) begin
      m_pre = 0; m_phase = P_AR; m_left = ART; m_active = 0; m_flash = 0;
      return;
    end
    t     = (m_pre == TDIV - 1);
    m_pre = (m_pre + 1) % TDIV;
    if (!t) return;
    gdur = (green_time == 0) ? 1 : int'(green_time);
    if (night_mode) begin
      m_flash = (m_phase == P_FL) ? !m_flash : 1'b1;
      m_phase = P_FL;
      m_left  = 0;
    end else if (m_phase == P_FL) begin
      m_phase = P_AR; m_left = ART;
    end else if (m_left > 1) begin
      m_left--;
    end else if (m_phase == P_AR) begin
      m_phase = P_GR; m_left = gdur;
    end else if (m_phase == P_GR) begin
      if (demand != 0 && demand == N'(1 << m_active)) m_left = gdur;
      else begin m_phase = P_YE; m_left = YT; end
    end else begin
      m_active = next_served(m_active, demand);
      m_phase  = P_AR; m_left = ART;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] er, ey, eg, lit;
    er = '1; ey = '0; eg = '0;
    for (int i = 0; i < N; i++) begin
      if (m_phase == P_FL) begin
        er[i] = 1'b0; ey[i] = m_flash;
      end else if (i == m_active && m_phase == P_GR) begin
        er[i] = 1'b0; eg[i] = 1'b1;
      end else if (i == m_active && m_phase == P_YE) begin
        er[i] = 1'b0; ey[i] = 1'b1;
      end
    end
    chk("red", 32'(red), 32'(er));
    chk("yellow", 32'(yellow), 32'(ey));
    chk("green", 32'(green), 32'(eg));
    chk("remain", 32'(remain), 32'(m_left));
    chk("active", 32'(active), 32'(m_active));
    chk("tick", 32'(tick), 32'(m_pre == TDIV - 1));
    if (m_phase != P_FL) begin
      lit = green | yellow;
      chk("lamp_invariant", 32'($countones(lit) <= 1 && (lit & red) == 0), 32'd1);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_phase(input int ph, input int act, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (m_phase == ph && (act < 0 || m_active == act)) hit = 1;
      else step();
    end
    if (!hit && !(m_phase == ph && (act < 0 || m_active == act)))
      chk("wait_timeout", 32'(m_phase), 32'(ph));
  endtask

  initial begin
    int saved;
    reset = 1'b1; green_time = 8'd5; demand = '0; night_mode = 1'b0;
    m_pre = 0; m_phase = P_AR; m_left = ART; m_active = 0; m_flash = 0;
    @(negedge clk);
    step();
    chk("rst_red", 32'(red), 32'hF);
    chk("rst_remain", 32'(remain), 32'd2);
    chk("rst_tick", 32'(tick), 32'd0);

    // first phase: Ticks after edges 3 and 7, GREEN[0] after edge 8
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("first_tick", 32'(tick), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("first_green", 32'(green), 32'h1);
    chk("first_remain", 32'(remain), 32'd5);

    // plain rotation through all approaches and back to 0
    for (int i = 0; i < 4 * 10 * TDIV + 8; i++) step();
    wait_phase(P_GR, 0, 200);
    chk("rot_back_to_0", 32'(green), 32'h1);

    // demand skip: serving 0, only approach 3 requests
    demand = 4'b1000;
    wait_phase(P_YE, 0, 100);
    wait_phase(P_AR, -1, 100);
    chk("skip_active", 32'(active), 32'd3);

    // extension: approach 2 alone keeps green
    demand = 4'b0100;
    wait_phase(P_GR, 2, 200);
    for (int i = 0; i < 3 * 5 * TDIV; i++) begin
      step();
      chk("ext_no_yellow", 32'(yellow), 32'd0);
    end
    demand = 4'b0101;
    wait_phase(P_YE, 2, 100);
    chk("ext_ends_yellow", 32'(yellow), 32'h4);

    // night pre-emption mid-green
    demand = '0;
    wait_phase(P_GR, -1, 200);
    for (int i = 0; i < 5; i++) step();
    saved = m_active;
    night_mode = 1'b1;
    wait_phase(P_FL, -1, 10);
    chk("flash_on", 32'(yellow), 32'hF);
    for (int i = 0; i < TDIV; i++) step();
    chk("flash_toggle", 32'(yellow), 32'h0);
    for (int i = 0; i < 6 * TDIV; i++) step();
    night_mode = 1'b0;
    wait_phase(P_AR, -1, 10);
    chk("night_exit_remain", 32'(remain), 32'd2);
    chk("night_exit_active", 32'(active), 32'(saved));

    // zero green time lasts a single tick
    green_time = 8'd0;
    wait_phase(P_GR, -1, 200);
    chk("g0_remain", 32'(remain), 32'd1);
    wait_phase(P_YE, -1, 2 * TDIV);
    green_time = 8'd5;

    // reset mid-yellow
    for (int i = 0; i < TDIV; i++) step();
    reset = 1'b1;
    step();
    chk("midrst_yellow", 32'(yellow), 32'd0);
    chk("midrst_active", 32'(active), 32'd0);
    chk("midrst_remain", 32'(remain), 32'd2);
    reset = 1'b0;

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) demand = N'($urandom);
      if ($urandom_range(0, 49) == 0) green_time = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) night_mode = ~night_mode;
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
